// File: rtl/wb_commit_if.sv
`default_nettype none
// ============================================================================
// Module  : wb_commit_if
// Brief   : Memory-stage, register-file/CSR write and fetch-side signals of
//           the write-back commit unit.
// Revision: 1.0
// ============================================================================
interface wb_commit_if #(
    parameter int DATA_WIDTH        = 32,
    parameter int REG_ADDR_WIDTH    = 5,
    parameter int RESULT_SRC_LENGTH = 2,
    parameter int CSR_ADDR_WIDTH    = 12,
    parameter int CNT_WIDTH         = 64
);
    logic                         Mvalid;
    logic                         Wready;
    logic [DATA_WIDTH-1:0]        ALUResult;
    logic [DATA_WIDTH-1:0]        ReadData;
    logic [DATA_WIDTH-1:0]        Pc;
    logic [DATA_WIDTH-1:0]        NextPc;
    logic [DATA_WIDTH-1:0]        CsrRdata;
    logic [RESULT_SRC_LENGTH-1:0] ResultSrc;
    logic                         RegWrite;
    logic [REG_ADDR_WIDTH-1:0]    Rd;
    logic                         CsrWrite;
    logic [CSR_ADDR_WIDTH-1:0]    CsrAddr;
    logic [DATA_WIDTH-1:0]        CsrWdata;
    logic                         Ecall;
    logic                         rf_wen;
    logic [REG_ADDR_WIDTH-1:0]    rf_waddr;
    logic [DATA_WIDTH-1:0]        rf_wdata;
    logic                         csr_wen;
    logic [CSR_ADDR_WIDTH-1:0]    csr_waddr;
    logic [DATA_WIDTH-1:0]        csr_wdata;
    logic                         Wvalid;
    logic                         Iready;
    logic [DATA_WIDTH-1:0]        next_pc;
    logic [CNT_WIDTH-1:0]         inst_count;

    // Environment side: memory stage, fetch stage and write targets
    modport master (
        output Mvalid, ALUResult, ReadData, Pc, NextPc, CsrRdata, ResultSrc,
               RegWrite, Rd, CsrWrite, CsrAddr, CsrWdata, Ecall, Iready,
        input  Wready, rf_wen, rf_waddr, rf_wdata, csr_wen, csr_waddr,
               csr_wdata, Wvalid, next_pc, inst_count
    );

    modport slave (
        input  Mvalid, ALUResult, ReadData, Pc, NextPc, CsrRdata, ResultSrc,
               RegWrite, Rd, CsrWrite, CsrAddr, CsrWdata, Ecall, Iready,
        output Wready, rf_wen, rf_waddr, rf_wdata, csr_wen, csr_waddr,
               csr_wdata, Wvalid, next_pc, inst_count
    );
endinterface
`default_nettype wire

// File: rtl/wb_commit_unit.sv
`default_nettype none
// ============================================================================
// Module  : wb_commit_unit
// Brief   : Write-back stage: selects the result, performs RF/CSR writes,
//           hands the next PC to fetch and counts retired instructions.
// Revision: 1.0
// ============================================================================
module wb_commit_unit #(
    parameter int DATA_WIDTH        = 32,
    parameter int REG_ADDR_WIDTH    = 5,
    parameter int RESULT_SRC_LENGTH = 2,
    parameter int CSR_ADDR_WIDTH    = 12,
    parameter int CNT_WIDTH         = 64
) (
    input  wire          clk,
    input  wire          rst,
    wb_commit_if.slave   bus
);
    localparam logic [CSR_ADDR_WIDTH-1:0]    c_mepc    = CSR_ADDR_WIDTH'('h341);
    localparam logic [CSR_ADDR_WIDTH-1:0]    c_mcause  = CSR_ADDR_WIDTH'('h342);
    localparam logic [DATA_WIDTH-1:0]        c_ecall_m = DATA_WIDTH'(11);
    localparam logic [RESULT_SRC_LENGTH-1:0] c_src_mem = RESULT_SRC_LENGTH'(1);
    localparam logic [RESULT_SRC_LENGTH-1:0] c_src_pc4 = RESULT_SRC_LENGTH'(2);
    localparam logic [RESULT_SRC_LENGTH-1:0] c_src_csr = RESULT_SRC_LENGTH'(3);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        TRAP   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic                        r_ecall;
    logic [DATA_WIDTH-1:0]       r_next_pc;

    logic                        w_capture;
    logic [DATA_WIDTH-1:0]       w_result;
    logic                        w_rf_wen;
    logic [REG_ADDR_WIDTH-1:0]   w_rf_waddr;
    logic [DATA_WIDTH-1:0]       w_rf_wdata;
    logic                        w_csr_wen;
    logic [CSR_ADDR_WIDTH-1:0]   w_csr_waddr;
    logic [DATA_WIDTH-1:0]       w_csr_wdata;
    logic                        w_wvalid;
    logic [DATA_WIDTH-1:0]       w_next_pc;
    logic [CNT_WIDTH-1:0]        w_inst_count;

    assign bus.Wready = (r_state == IDLE);
    assign w_capture  = (r_state == IDLE) && bus.Mvalid;

    // Write-stage outputs are registered, so they are loaded from the
    // instruction fields on the capture edge itself.
    always_comb begin
        w_result = bus.ALUResult;
        case (bus.ResultSrc)
            c_src_mem: w_result = bus.ReadData;
            c_src_pc4: w_result = bus.Pc + DATA_WIDTH'(4);
            c_src_csr: w_result = bus.CsrRdata;
            default:   w_result = bus.ALUResult;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_rf_wen     = 1'b0;
        w_rf_waddr   = bus.rf_waddr;
        w_rf_wdata   = bus.rf_wdata;
        w_csr_wen    = 1'b0;
        w_csr_waddr  = bus.csr_waddr;
        w_csr_wdata  = bus.csr_wdata;
        w_wvalid     = 1'b0;
        w_next_pc    = bus.next_pc;
        w_inst_count = bus.inst_count;

        case (r_state)
            IDLE: begin
                if (bus.Mvalid) begin
                    w_state_next = WRITE;
                    if (bus.RegWrite && (bus.Rd != '0)) begin
                        w_rf_wen   = 1'b1;
                        w_rf_waddr = bus.Rd;
                        w_rf_wdata = w_result;
                    end
                    if (bus.Ecall) begin
                        w_csr_wen   = 1'b1;
                        w_csr_waddr = c_mepc;
                        w_csr_wdata = bus.Pc;
                    end else if (bus.CsrWrite) begin
                        w_csr_wen   = 1'b1;
                        w_csr_waddr = bus.CsrAddr;
                        w_csr_wdata = bus.CsrWdata;
                    end
                end
            end
            WRITE: begin
                if (r_ecall) begin
                    w_state_next = TRAP;
                    w_csr_wen    = 1'b1;
                    w_csr_waddr  = c_mcause;
                    w_csr_wdata  = c_ecall_m;
                end else begin
                    w_state_next = COMMIT;
                    w_wvalid     = 1'b1;
                    w_next_pc    = r_next_pc;
                end
            end
            TRAP: begin
                w_state_next = COMMIT;
                w_wvalid     = 1'b1;
                w_next_pc    = r_next_pc;
            end
            COMMIT: begin
                if (bus.Iready) begin
                    w_state_next = IDLE;
                    w_inst_count = bus.inst_count + CNT_WIDTH'(1);
                end else begin
                    w_wvalid = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_ecall        <= 1'b0;
            r_next_pc      <= '0;
            bus.rf_wen     <= 1'b0;
            bus.rf_waddr   <= '0;
            bus.rf_wdata   <= '0;
            bus.csr_wen    <= 1'b0;
            bus.csr_waddr  <= '0;
            bus.csr_wdata  <= '0;
            bus.Wvalid     <= 1'b0;
            bus.next_pc    <= '0;
            bus.inst_count <= '0;
        end else begin
            r_state        <= w_state_next;
            bus.rf_wen     <= w_rf_wen;
            bus.rf_waddr   <= w_rf_waddr;
            bus.rf_wdata   <= w_rf_wdata;
            bus.csr_wen    <= w_csr_wen;
            bus.csr_waddr  <= w_csr_waddr;
            bus.csr_wdata  <= w_csr_wdata;
            bus.Wvalid     <= w_wvalid;
            bus.next_pc    <= w_next_pc;
            bus.inst_count <= w_inst_count;
            if (w_capture) begin
                r_ecall   <= bus.Ecall;
                r_next_pc <= bus.NextPc;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_wb_commit_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_commit_unit
// Brief   : Directed and randomized checks of wb_commit_unit against a
//           transaction-level reference model.
// Revision: 1.0
// ============================================================================
module tb_wb_commit_unit;
    logic clk;
    logic rst;

    wb_commit_if #(
        .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .RESULT_SRC_LENGTH(2),
        .CSR_ADDR_WIDTH(12), .CNT_WIDTH(64)
    ) bus ();

    wb_commit_unit #(
        .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .RESULT_SRC_LENGTH(2),
        .CSR_ADDR_WIDTH(12), .CNT_WIDTH(64)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: retired count and last values seen on each write port
    logic [63:0] m_count;
    logic [4:0]  m_rf_addr;
    logic [31:0] m_rf_data;
    logic [11:0] m_csr_addr;
    logic [31:0] m_csr_data;
    logic [31:0] m_npc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] src, input logic [31:0] alu,
                                               input logic [31:0] rdata, input logic [31:0] pc,
                                               input logic [31:0] csrr);
        logic [31:0] pc4;
        pc4 = pc + 32'd4;
        if (src == 2'd1) return rdata;
        if (src == 2'd2) return pc4;
        if (src == 2'd3) return csrr;
        return alu;
    endfunction

    task automatic scramble_inputs(input logic mvalid);
        bus.Mvalid    = mvalid;
        bus.ALUResult = $urandom;
        bus.ReadData  = $urandom;
        bus.Pc        = $urandom;
        bus.NextPc    = $urandom;
        bus.CsrRdata  = $urandom;
        bus.ResultSrc = 2'($urandom_range(0, 3));
        bus.RegWrite  = 1'($urandom);
        bus.Rd        = 5'($urandom);
        bus.CsrWrite  = 1'($urandom);
        bus.CsrAddr   = 12'($urandom);
        bus.CsrWdata  = $urandom;
        bus.Ecall     = 1'($urandom);
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, ".wready"},  64'(bus.Wready), 64'd1);
        check({tag, ".wvalid"},  64'(bus.Wvalid), 64'd0);
        check({tag, ".rf_wen"},  64'(bus.rf_wen), 64'd0);
        check({tag, ".csr_wen"}, 64'(bus.csr_wen), 64'd0);
        check({tag, ".rf_data"}, 64'(bus.rf_wdata), 64'd0);
        check({tag, ".csr_adr"}, 64'(bus.csr_waddr), 64'd0);
        check({tag, ".next_pc"}, 64'(bus.next_pc), 64'd0);
        check({tag, ".count"},   bus.inst_count, 64'd0);
    endtask

    task automatic run_instr(input logic [1:0] src, input logic [31:0] alu,
                             input logic [31:0] rdata, input logic [31:0] pc,
                             input logic [31:0] npc, input logic [31:0] csrr,
                             input logic regw, input logic [4:0] rd,
                             input logic csrw, input logic [11:0] caddr,
                             input logic [31:0] cwd, input logic ecall,
                             input int stall, input logic noisy);
        logic exp_rfw;
        logic exp_csrw;
        exp_rfw  = regw && (rd != 5'd0);
        exp_csrw = ecall || csrw;

        check("idle.wready", 64'(bus.Wready), 64'd1);
        bus.Mvalid = 1'b1; bus.ALUResult = alu; bus.ReadData = rdata; bus.Pc = pc;
        bus.NextPc = npc; bus.CsrRdata = csrr; bus.ResultSrc = src; bus.RegWrite = regw;
        bus.Rd = rd; bus.CsrWrite = csrw; bus.CsrAddr = caddr; bus.CsrWdata = cwd;
        bus.Ecall = ecall; bus.Iready = 1'b0;
        step();
        scramble_inputs(noisy ? 1'($urandom) : 1'b0);

        // First cycle after capture: register-file and first CSR write
        if (exp_rfw) begin
            m_rf_addr = rd;
            m_rf_data = ref_result(src, alu, rdata, pc, csrr);
        end
        if (ecall) begin
            m_csr_addr = 12'h341; m_csr_data = pc;
        end else if (csrw) begin
            m_csr_addr = caddr; m_csr_data = cwd;
        end
        check("w1.rf_wen",  64'(bus.rf_wen), 64'(exp_rfw));
        check("w1.rf_addr", 64'(bus.rf_waddr), 64'(m_rf_addr));
        check("w1.rf_data", 64'(bus.rf_wdata), 64'(m_rf_data));
        check("w1.csr_wen", 64'(bus.csr_wen), 64'(exp_csrw));
        check("w1.csr_adr", 64'(bus.csr_waddr), 64'(m_csr_addr));
        check("w1.csr_dat", 64'(bus.csr_wdata), 64'(m_csr_data));
        check("w1.wvalid",  64'(bus.Wvalid), 64'd0);
        check("w1.wready",  64'(bus.Wready), 64'd0);

        if (ecall) begin
            step();
            scramble_inputs(noisy ? 1'($urandom) : 1'b0);
            m_csr_addr = 12'h342; m_csr_data = 32'd11;
            check("tr.rf_wen",  64'(bus.rf_wen), 64'd0);
            check("tr.csr_wen", 64'(bus.csr_wen), 64'd1);
            check("tr.csr_adr", 64'(bus.csr_waddr), 64'(m_csr_addr));
            check("tr.csr_dat", 64'(bus.csr_wdata), 64'(m_csr_data));
            check("tr.wvalid",  64'(bus.Wvalid), 64'd0);
        end

        m_npc = npc;
        for (int k = 0; k <= stall; k++) begin
            step();
            scramble_inputs(noisy ? 1'($urandom) : 1'b1);
            check("cm.wvalid",  64'(bus.Wvalid), 64'd1);
            check("cm.next_pc", 64'(bus.next_pc), 64'(m_npc));
            check("cm.wready",  64'(bus.Wready), 64'd0);
            check("cm.rf_wen",  64'(bus.rf_wen), 64'd0);
            check("cm.csr_wen", 64'(bus.csr_wen), 64'd0);
            check("cm.rf_hold", 64'(bus.rf_wdata), 64'(m_rf_data));
            check("cm.csr_hld", 64'(bus.csr_waddr), 64'(m_csr_addr));
            check("cm.count",   bus.inst_count, m_count);
            bus.Iready = (k == stall);
        end
        step();
        m_count    = m_count + 64'd1;
        bus.Iready = 1'b0;
        bus.Mvalid = 1'b0;
        check("done.wvalid", 64'(bus.Wvalid), 64'd0);
        check("done.wready", 64'(bus.Wready), 64'd1);
        check("done.count",  bus.inst_count, m_count);
        check("done.npc",    64'(bus.next_pc), 64'(m_npc));
    endtask

    task automatic clear_model();
        m_count = '0; m_rf_addr = '0; m_rf_data = '0;
        m_csr_addr = '0; m_csr_data = '0; m_npc = '0;
    endtask

    initial begin
        clear_model();
        rst = 1'b1;
        bus.Iready = 1'b0;
        scramble_inputs(1'b1);
        step();
        step();
        check_idle_reset("rst");
        rst = 1'b0;
        bus.Mvalid = 1'b0;
        step();

        // ALU, load to x0, jal wrapping PC, ecall, backpressure with Mvalid held
        run_instr(2'd0, 32'h1234, 32'h0, 32'h8000_0000, 32'h8000_0004, 32'h0,
                  1'b1, 5'd5, 1'b0, 12'h0, 32'h0, 1'b0, 0, 1'b0);
        run_instr(2'd1, 32'h0, 32'hDEAD_BEEF, 32'h8000_0004, 32'h8000_0008, 32'h0,
                  1'b1, 5'd0, 1'b0, 12'h0, 32'h0, 1'b0, 0, 1'b0);
        run_instr(2'd2, 32'h5555, 32'h0, 32'hFFFF_FFFC, 32'h0000_0040, 32'h0,
                  1'b1, 5'd1, 1'b0, 12'h0, 32'h0, 1'b0, 0, 1'b0);
        run_instr(2'd0, 32'h0, 32'h0, 32'h8000_0100, 32'h8000_1000, 32'h0,
                  1'b0, 5'd0, 1'b0, 12'h0, 32'h0, 1'b1, 0, 1'b0);
        run_instr(2'd3, 32'h0, 32'h0, 32'h8000_0200, 32'h8000_0204, 32'hCAFE_0001,
                  1'b1, 5'd9, 1'b1, 12'h305, 32'h8000_1000, 1'b0, 5, 1'b0);

        // Reset while in WRITE drops the instruction
        bus.Mvalid = 1'b1; bus.ALUResult = 32'h77; bus.ResultSrc = 2'd0;
        bus.RegWrite = 1'b1; bus.Rd = 5'd3; bus.Ecall = 1'b0; bus.CsrWrite = 1'b1;
        bus.NextPc = 32'h1000;
        step();
        bus.Mvalid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_model();
        check_idle_reset("rstw");
        step();
        check("rstw.idle_cnt", bus.inst_count, 64'd0);
        run_instr(2'd0, 32'hABCD, 32'h0, 32'h10, 32'h14, 32'h0,
                  1'b1, 5'd7, 1'b0, 12'h0, 32'h0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] pc;
            logic [4:0]  rd;
            pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            run_instr(2'($urandom_range(0, 3)), $urandom, $urandom, pc, $urandom, $urandom,
                      1'($urandom), rd, 1'($urandom), 12'($urandom), $urandom,
                      ($urandom_range(0, 4) == 0), $urandom_range(0, 3), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
